alu_issue_decode: RTL
=====================

Name: alu_issue_decode

Overview:
- Producer side of the ALU operand/select interface.
- Accepts one RV32I instruction per handshake, together with its register-file read data and PC.
- Decodes it into opA, opB and the 4-bit aluOutSel, and registers the result in a single pipeline stage with valid/ready flow control toward the ALU stage.
- Sits between register read and the ALU in the core datapath.

Parameters:
- XLEN, 32, datapath width of operands and PC.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream instruction valid
- in_ready  output  1  block can accept an instruction this cycle
- instr  input  32  RV32I instruction word
- rs1_data  input  XLEN  register-file value for rs1
- rs2_data  input  XLEN  register-file value for rs2
- pc  input  XLEN  PC of instr
- out_valid  output  1  opA/opB/aluOutSel hold a decoded op
- out_ready  input  1  ALU stage accepts the op
- opA  output  XLEN  ALU operand A
- opB  output  XLEN  ALU operand B
- aluOutSel  output  4  ALU operation select
- illegal  output  1  current output op came from an undecodable instruction
- issued_cnt  output  CNT_W  count of completed output handshakes
- illegal_cnt  output  CNT_W  count of issued ops with illegal=1

Behaviour:
- Reset values: out_valid=0, opA=0, opB=0, aluOutSel=4'b0000, illegal=0, issued_cnt=0, illegal_cnt=0.
- rst takes priority over all other activity. Asserting rst mid-transfer discards the held op with no handshake counted.
- in_ready = !out_valid || out_ready. This is combinational, with no bubble under continuous flow.
- Input handshake (in_valid && in_ready):
  - the output register loads the decoded op on the next edge;
  - out_valid=1 on that edge;
  - latency is exactly 1 cycle.
- Output handshake (out_valid && out_ready) with no new input on the same cycle: out_valid goes to 0 on the next edge.
- Simultaneous input and output handshake on the same cycle: the register reloads and out_valid stays 1.
- Stall (out_valid && !out_ready): opA, opB, aluOutSel and illegal hold stable, and in_ready=0.
- aluOutSel encoding:
  - 0000 add, 0001 sub, 0010 xor, 0011 or, 0100 and;
  - 0101 sll, 0110 srl, 0111 sra;
  - 1000 slt, 1001 sltu;
  - 1010–1111 never driven.
- Decode by opcode (instr[6:0]):
  - 0110011 R-type: opA=rs1_data, opB=rs2_data. funct3/funct7 mapping:
    - 000/0000000 add, 000/0100000 sub;
    - 001/0000000 sll;
    - 010/0000000 slt, 011/0000000 sltu;
    - 100/0000000 xor;
    - 101/0000000 srl, 101/0100000 sra;
    - 110/0000000 or, 111/0000000 and;
    - any other funct7 is illegal.
  - 0010011 I-type: opA=rs1_data, opB=sign-extended instr[31:20].
    - funct3 maps as R-type, with no sub.
    - For 001, 101: opB={27'b0, instr[24:20]}; instr[31:25] must be 0000000 (sll/srl) or 0100000 (sra, funct3 101 only), otherwise illegal.
  - 0110111 LUI: opA=0, opB={instr[31:12],12'b0}, add.
  - 0010111 AUIPC: opA=pc, opB={instr[31:12],12'b0}, add.
  - 0000011 load: opA=rs1_data, opB=sext(instr[31:20]), add.
  - 0100011 store: opA=rs1_data, opB=sext({instr[31:25],instr[11:7]}), add.
  - Any other opcode is illegal.
- Illegal op: issued normally with illegal=1, opA=0, opB=0, aluOutSel=0000. It is never dropped.
- issued_cnt increments by 1 on each output handshake and wraps from all-ones to 0.
- illegal_cnt increments on an output handshake when illegal=1 and wraps the same way.

Test Plan:
- Reset, then instr=0x002081B3 (add) with rs1_data=5, rs2_data=7, pc=0, out_ready=1 -> next cycle out_valid=1, opA=5, opB=7, aluOutSel=0000, illegal=0; issued_cnt=1 after the handshake.
- instr=0x402081B3 (sub) -> aluOutSel=0001. instr=0xFFF00093 (addi -1) with rs1_data=0 -> opB=0xFFFFFFFF, aluOutSel=0000.
- instr=0x123450B7 (LUI) -> opA=0, opB=0x12345000. instr=0x00001097 (AUIPC) with pc=0x100 -> opA=0x100, opB=0x1000.
- instr=0x4020D093 (srai x1,x1,2) -> aluOutSel=0111, opB=2. instr=0x0000001B (bad opcode) -> illegal=1, opA=opB=0, illegal_cnt increments.
- Backpressure: issue two back-to-back ops with out_ready=0 for 3 cycles -> the first op holds stable, in_ready=0, the second instr is not accepted. Release out_ready -> both ops delivered in order, issued_cnt=2.
- Assert rst for 1 cycle while out_valid=1 and out_ready=0 -> out_valid=0, all outputs and counters reset next cycle, no handshake counted. Force issued_cnt to all-ones, then perform one handshake -> issued_cnt=0.

Source files
------------

// File: rtl/alu_issue_decode.sv
// alu_issue_decode
//   Producer side of the ALU operand/select interface. Takes one RV32I
//   instruction per handshake, together with its register-file read data and
//   PC. It decodes the instruction into ALU operand A, operand B and a 4-bit
//   operation select. The result goes into one valid/ready pipeline register
//   toward the ALU stage.
//
// Ports
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : upstream handshake (in_ready = !out_valid || out_ready)
//   instr                : RV32I instruction word
//   rs1_data, rs2_data   : register-file values for rs1 / rs2
//   pc                   : PC of instr
//   out_valid/out_ready  : downstream handshake toward the ALU
//   opA, opB, aluOutSel  : registered ALU operands and operation select
//   illegal              : held op came from an undecodable instruction
//   issued_cnt           : completed output handshakes (wraps)
//   illegal_cnt          : completed output handshakes with illegal=1 (wraps)
module alu_issue_decode #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic [XLEN-1:0]  pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  opA,
    output logic [XLEN-1:0]  opB,
    output logic [3:0]       aluOutSel,
    output logic             illegal,
    output logic [CNT_W-1:0] issued_cnt,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_XOR  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_AND  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_sel_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    // ------------------------------------------------------------------
    // Instruction fields and immediates
    // ------------------------------------------------------------------
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] shamt;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = XLEN'($signed(instr[31:20]));
    assign imm_s  = XLEN'($signed({instr[31:25], instr[11:7]}));
    assign imm_u  = XLEN'($signed({instr[31:12], 12'b0}));
    assign shamt  = XLEN'(instr[24:20]);

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    alu_sel_e        base_sel;
    logic [XLEN-1:0] dec_op_a;
    logic [XLEN-1:0] dec_op_b;
    alu_sel_e        dec_sel;
    logic            dec_illegal;

    // funct3 -> operation shared by R-type and I-type; the funct7 alternates
    // (sub, sra) are applied on top of this.
    always_comb begin
        // NOTE: every variable assigned in a combinational block gets a
        // default first, so no path can leave it unassigned and infer a latch.
        base_sel = ALU_ADD;
        case (funct3)
            3'b000:  base_sel = ALU_ADD;
            3'b001:  base_sel = ALU_SLL;
            3'b010:  base_sel = ALU_SLT;
            3'b011:  base_sel = ALU_SLTU;
            3'b100:  base_sel = ALU_XOR;
            3'b101:  base_sel = ALU_SRL;
            3'b110:  base_sel = ALU_OR;
            default: base_sel = ALU_AND;
        endcase
    end

    always_comb begin
        dec_op_a    = '0;
        dec_op_b    = '0;
        dec_sel     = ALU_ADD;
        dec_illegal = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_op_a = rs1_data;
                dec_op_b = rs2_data;
                dec_sel  = base_sel;
                if (funct7 == F7_ALT && funct3 == 3'b000)      dec_sel     = ALU_SUB;
                else if (funct7 == F7_ALT && funct3 == 3'b101) dec_sel     = ALU_SRA;
                else if (funct7 != F7_ZERO)                    dec_illegal = 1'b1;
            end
            OPC_OP_IMM: begin
                dec_op_a = rs1_data;
                dec_sel  = base_sel;
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    // Shift-immediates: instr[31:25] is an encoding field, not immediate bits.
                    dec_op_b = shamt;
                    if (funct3 == 3'b101 && funct7 == F7_ALT) dec_sel     = ALU_SRA;
                    else if (funct7 != F7_ZERO)               dec_illegal = 1'b1;
                end else begin
                    dec_op_b = imm_i;
                end
            end
            OPC_LUI: begin
                dec_op_b = imm_u;
            end
            OPC_AUIPC: begin
                dec_op_a = pc;
                dec_op_b = imm_u;
            end
            OPC_LOAD: begin
                dec_op_a = rs1_data;
                dec_op_b = imm_i;
            end
            OPC_STORE: begin
                dec_op_a = rs1_data;
                dec_op_b = imm_s;
            end
            default: dec_illegal = 1'b1;
        endcase
        // Illegal ops still flow to the ALU, but as a harmless 0 + 0.
        if (dec_illegal) begin
            dec_op_a = '0;
            dec_op_b = '0;
            dec_sel  = ALU_ADD;
        end
    end

    // ------------------------------------------------------------------
    // Output pipeline register and counters
    // ------------------------------------------------------------------
    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  op_a_q, op_a_d;
    logic [XLEN-1:0]  op_b_q, op_b_d;
    alu_sel_e         sel_q, sel_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] issued_cnt_q, issued_cnt_d;
    logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;
    logic             hs_in;
    logic             hs_out;

    // Register is free when empty or being drained this cycle: no bubble.
    assign in_ready = !out_valid_q || out_ready;
    assign hs_in    = in_valid && in_ready;
    assign hs_out   = out_valid_q && out_ready;

    always_comb begin
        out_valid_d   = out_valid_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        sel_d         = sel_q;
        illegal_d     = illegal_q;
        issued_cnt_d  = issued_cnt_q;
        illegal_cnt_d = illegal_cnt_q;
        if (hs_in) begin
            out_valid_d = 1'b1;
            op_a_d      = dec_op_a;
            op_b_d      = dec_op_b;
            sel_d       = dec_sel;
            illegal_d   = dec_illegal;
        end else if (hs_out) begin
            out_valid_d = 1'b0;
        end
        if (hs_out) begin
            issued_cnt_d  = issued_cnt_q + 1'b1;
            illegal_cnt_d = illegal_cnt_q + CNT_W'(illegal_q);
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            sel_q         <= ALU_ADD;
            illegal_q     <= 1'b0;
            issued_cnt_q  <= '0;
            illegal_cnt_q <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            sel_q         <= sel_d;
            illegal_q     <= illegal_d;
            issued_cnt_q  <= issued_cnt_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign opA         = op_a_q;
    assign opB         = op_b_q;
    assign aluOutSel   = sel_q;
    assign illegal     = illegal_q;
    assign issued_cnt  = issued_cnt_q;
    assign illegal_cnt = illegal_cnt_q;

endmodule
